// File: rtl/fruit_scheduler.sv
// fruit_scheduler: launch scheduler for the falling-fruit slot pool.
// Latency: final frame_tick at edge T -> PICK at T+1 -> launch pulse and fields after T+2.
// Backpressure: none; when every slot is busy the attempt is dropped and counted in drop_count.
//
// Ports:
//   Clk, Reset_n         clock, asynchronous active-low reset
//   frame_tick, game_en  one-cycle frame pulse, scheduling enable
//   slot_done            per-slot release pulse (sliced / off-screen)
//   launch               one-hot, one-cycle launch pulse
//   launch_x/vx/vy/type  launch fields, held until the next launch
//   slot_busy            slot occupancy
//   drop_count           saturating count of attempts that found no free slot
//   launch_bomb          (FRUIT_SCHED_BOMB_EN only) asserted with launch for a type-3 fruit
//
// Optional feature macro: FRUIT_SCHED_BOMB_EN (bomb type with at most one bomb in flight).

module fruit_scheduler #(
  parameter int unsigned NUM_SLOTS        = 4,
  parameter int unsigned SPAWN_MIN        = 30,
  parameter int unsigned SPAWN_RANGE_LOG2 = 5,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 game_en,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [9:0]           launch_x,
  output logic [9:0]           launch_vx,
  output logic [9:0]           launch_vy,
  output logic [1:0]           launch_type,
`ifdef FRUIT_SCHED_BOMB_EN
  output logic                 launch_bomb,
`endif
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [7:0]           drop_count
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  // Mask selecting the low SPAWN_RANGE_LOG2 LFSR bits; zero when the interval is fixed.
  localparam logic [8:0] RANGE_MASK = 9'((1 << SPAWN_RANGE_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PICK,
    S_LAUNCH
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [8:0]         timer;
  logic [IDX_W-1:0]   pick_idx;

  logic [15:0]        lfsr_next;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [8:0]         reload;
  logic               launch_fire;
  logic [NUM_SLOTS-1:0] launch_set;
  logic [9:0]         next_x;
  logic [9:0]         next_vx;
  logic [9:0]         next_vy;
  logic [1:0]         next_type;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

  assign reload = 9'(SPAWN_MIN) + ({1'b0, lfsr[7:0]} & RANGE_MASK);

  // Lowest-index free slot; scanning downward lets the last hit win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // A launch only happens if the game is still enabled in the LAUNCH cycle.
  assign launch_fire = (state == S_LAUNCH) && game_en;
  assign launch_set  = launch_fire ? (NUM_SLOTS'(1) << pick_idx) : '0;

  assign next_x  = 10'd64 + {1'b0, lfsr[8:0]};
  assign next_vy = 10'd0 - (10'd8 + {8'd0, lfsr[12:11]});

  always_comb begin
    next_vx = 10'd0;
    case (lfsr[10:9])
      2'b00:   next_vx = 10'h3FE;
      2'b01:   next_vx = 10'h3FF;
      2'b10:   next_vx = 10'd1;
      default: next_vx = 10'd2;
    endcase
  end

`ifdef FRUIT_SCHED_BOMB_EN
  logic                 bomb_flight;
  logic [NUM_SLOTS-1:0] bomb_slot;

  // A second bomb is demoted to an ordinary type-0 fruit.
  assign next_type = ((lfsr[14:13] == 2'd3) && bomb_flight) ? 2'd0 : lfsr[14:13];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bomb_flight <= 1'b0;
      bomb_slot   <= '0;
      launch_bomb <= 1'b0;
    end else begin
      launch_bomb <= 1'b0;
      if (bomb_flight && ((slot_done & bomb_slot) != '0)) begin
        bomb_flight <= 1'b0;
      end
      if (launch_fire && (next_type == 2'd3)) begin
        bomb_flight <= 1'b1;
        bomb_slot   <= launch_set;
        launch_bomb <= 1'b1;
      end
    end
  end
`else
  assign next_type = lfsr[14:13];
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      timer       <= 9'd0;
      pick_idx    <= '0;
      launch      <= '0;
      launch_x    <= 10'd0;
      launch_vx   <= 10'd0;
      launch_vy   <= 10'd0;
      launch_type <= 2'd0;
      slot_busy   <= '0;
      drop_count  <= 8'd0;
    end else begin
      launch <= '0;
      if (game_en) begin
        lfsr <= lfsr_next;
      end

      // Releases and a launch to a different slot merge in one update.
      slot_busy <= (slot_busy & ~slot_done) | launch_set;

      if (!game_en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            timer <= 9'(SPAWN_MIN);
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (frame_tick) begin
              timer <= (timer == 9'd0) ? 9'd0 : timer - 9'd1;
              if (timer <= 9'd1) begin
                state <= S_PICK;
              end
            end
          end
          S_PICK: begin
            if (free_found) begin
              pick_idx <= free_idx;
              state    <= S_LAUNCH;
            end else begin
              if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
              timer <= reload;
              state <= S_WAIT;
            end
          end
          default: begin
            launch      <= launch_set;
            launch_x    <= next_x;
            launch_vx   <= next_vx;
            launch_vy   <= next_vy;
            launch_type <= next_type;
            timer       <= reload;
            state       <= S_WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fruit_scheduler.sv
// Testbench for fruit_scheduler (SPAWN_MIN=2, fixed interval, frame_tick every 10 clocks).
// Table-driven interval expiries plus hand sequences for merge, disable and reset cases.
// Expected launch fields come from an independent LFSR model of the spec polynomial.

module tb_fruit_scheduler;

  localparam int NS = 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          game_en = 1'b0;
  logic [NS-1:0] slot_done = '0;
  logic [NS-1:0] launch;
  logic [9:0]    launch_x;
  logic [9:0]    launch_vx;
  logic [9:0]    launch_vy;
  logic [1:0]    launch_type;
  logic [NS-1:0] slot_busy;
  logic [7:0]    drop_count;
`ifdef FRUIT_SCHED_BOMB_EN
  logic          launch_bomb;
`endif

  fruit_scheduler #(
    .NUM_SLOTS(NS),
    .SPAWN_MIN(2),
    .SPAWN_RANGE_LOG2(0),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_tick(frame_tick),
    .game_en(game_en),
    .slot_done(slot_done),
    .launch(launch),
    .launch_x(launch_x),
    .launch_vx(launch_vx),
    .launch_vy(launch_vy),
    .launch_type(launch_type),
`ifdef FRUIT_SCHED_BOMB_EN
    .launch_bomb(launch_bomb),
`endif
    .slot_busy(slot_busy),
    .drop_count(drop_count)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference LFSR: lprev is the value the DUT used at the most recent edge.
  logic [15:0] lm;
  logic [15:0] lprev;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lm    <= 16'hACE1;
      lprev <= 16'hACE1;
    end else begin
      lprev <= lm;
      if (game_en) lm <= lstep(lm);
    end
  end

  logic          m_bomb = 1'b0;
  logic [NS-1:0] m_bomb_mask = '0;
  logic [NS-1:0] m_busy;
  logic [7:0]    m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic one_tick();
    repeat (9) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic expire();
    one_tick();
    one_tick();
  endtask

  function automatic logic [NS-1:0] lowfree(input logic [NS-1:0] b);
    for (int i = 0; i < NS; i++) begin
      if (!b[i]) return NS'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_done(input logic [NS-1:0] d);
    if (m_bomb && ((d & m_bomb_mask) != '0)) m_bomb = 1'b0;
  endtask

  // Compare the launch pulse and, for a real launch, every field against the model.
  task automatic check_launch(input string nm, input logic [NS-1:0] exp_l);
    logic [15:0] l;
    logic [9:0]  ex, evx, evy;
    logic [1:0]  et;
    chk({nm, ".launch"}, 32'(launch), 32'(exp_l));
    if (exp_l != '0) begin
      l   = lprev;
      ex  = 10'd64 + {1'b0, l[8:0]};
      evy = 10'd0 - 10'(8 + l[12:11]);
      case (l[10:9])
        2'b00:   evx = 10'h3FE;
        2'b01:   evx = 10'h3FF;
        2'b10:   evx = 10'd1;
        default: evx = 10'd2;
      endcase
      et = l[14:13];
`ifdef FRUIT_SCHED_BOMB_EN
      if (et == 2'd3 && m_bomb) et = 2'd0;
      chk({nm, ".bomb"}, 32'(launch_bomb), 32'(et == 2'd3));
      if (et == 2'd3) begin
        m_bomb      = 1'b1;
        m_bomb_mask = exp_l;
      end
`endif
      chk({nm, ".x"}, 32'(launch_x), 32'(ex));
      chk({nm, ".vx"}, 32'(launch_vx), 32'(evx));
      chk({nm, ".vy"}, 32'(launch_vy), 32'(evy));
      chk({nm, ".type"}, 32'(launch_type), 32'(et));
    end
  endtask

  typedef struct {
    logic [NS-1:0] done;
    logic [NS-1:0] busy_after_done;
    logic [NS-1:0] exp_launch;
    logic [NS-1:0] busy_after;
    logic [7:0]    drop;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd0};
    tbl[1] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 8'd0};
    tbl[2] = '{4'b0000, 4'b0011, 4'b0100, 4'b0111, 8'd0};
    tbl[3] = '{4'b0000, 4'b0111, 4'b1000, 4'b1111, 8'd0};
    tbl[4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 8'd1};
    tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 8'd2};
    tbl[6] = '{4'b0100, 4'b1011, 4'b0100, 4'b1111, 8'd2};
    tbl[7] = '{4'b0011, 4'b1100, 4'b0001, 4'b1101, 8'd2};
    tbl[8] = '{4'b0010, 4'b1101, 4'b0010, 4'b1111, 8'd2};

    // Reset state.
    step();
    step();
    chk("rst.launch", 32'(launch), 32'd0);
    chk("rst.x", 32'(launch_x), 32'd0);
    chk("rst.vx", 32'(launch_vx), 32'd0);
    chk("rst.vy", 32'(launch_vy), 32'd0);
    chk("rst.type", 32'(launch_type), 32'd0);
    chk("rst.busy", 32'(slot_busy), 32'd0);
    chk("rst.drop", 32'(drop_count), 32'd0);
    chk("rst.lfsr", 32'(dut.lfsr), 32'hACE1);
    Reset_n = 1'b1;
    step();
    game_en = 1'b1;
    step();

    // Interval expiries: fill, drop, release and refill.
    for (int i = 0; i < 9; i++) begin
      slot_done = tbl[i].done;
      step();
      slot_done = '0;
      model_done(tbl[i].done);
      chk($sformatf("v%0d.busy_done", i), 32'(slot_busy), 32'(tbl[i].busy_after_done));
      expire();
      step();
      chk($sformatf("v%0d.early", i), 32'(launch), 32'd0);
      step();
      check_launch($sformatf("v%0d", i), tbl[i].exp_launch);
      chk($sformatf("v%0d.busy", i), 32'(slot_busy), 32'(tbl[i].busy_after));
      chk($sformatf("v%0d.drop", i), 32'(drop_count), 32'(tbl[i].drop));
      step();
      chk($sformatf("v%0d.pulse_end", i), 32'(launch), 32'd0);
    end

    // Release everything, launch slot 0, then release slot 0 in the cycle slot 1 launches.
    slot_done = 4'b1111;
    step();
    slot_done = '0;
    model_done(4'b1111);
    chk("rel.busy", 32'(slot_busy), 32'd0);
    expire();
    step();
    step();
    check_launch("m0", 4'b0001);
    expire();
    step();
    slot_done = 4'b0001;
    step();
    slot_done = '0;
    check_launch("m1", 4'b0010);
    model_done(4'b0001);
    chk("merge.busy", 32'(slot_busy), 32'b0010);

    // game_en dropped while in PICK.
    expire();
    game_en = 1'b0;
    step();
    chk("dis.launch1", 32'(launch), 32'd0);
    step();
    chk("dis.launch2", 32'(launch), 32'd0);
    chk("dis.busy", 32'(slot_busy), 32'b0010);
    slot_done = 4'b0010;
    step();
    slot_done = '0;
    model_done(4'b0010);
    chk("dis.done", 32'(slot_busy), 32'd0);
    game_en = 1'b1;
    step();
    // From IDLE the timer restarts, so a single tick must not launch.
    one_tick();
    step();
    step();
    chk("reen.one_tick", 32'(launch), 32'd0);
    one_tick();
    step();
    step();
    check_launch("reen", 4'b0001);

    // Reset pulsed mid-WAIT.
    one_tick();
    Reset_n = 1'b0;
    #1;
    chk("mrst.launch", 32'(launch), 32'd0);
    chk("mrst.x", 32'(launch_x), 32'd0);
    chk("mrst.vx", 32'(launch_vx), 32'd0);
    chk("mrst.vy", 32'(launch_vy), 32'd0);
    chk("mrst.type", 32'(launch_type), 32'd0);
    chk("mrst.busy", 32'(slot_busy), 32'd0);
    chk("mrst.drop", 32'(drop_count), 32'd0);
    chk("mrst.lfsr", 32'(dut.lfsr), 32'hACE1);
    m_bomb = 1'b0;
    step();
    Reset_n = 1'b1;
    step();

    // 1000 frames with random releases; busy/drop tracked by the model.
    m_busy = '0;
    m_drop = 8'd0;
    for (int e = 0; e < 500; e++) begin
      logic [NS-1:0] exp_l;
      logic [NS-1:0] d;
      expire();
      exp_l = lowfree(m_busy);
      step();
      chk("rnd.early", 32'(launch), 32'd0);
      step();
      check_launch("rnd", exp_l);
      if (exp_l != '0) begin
        m_busy = m_busy | exp_l;
        chk("rnd.onehot", 32'($onehot(launch)), 32'd1);
        chk("rnd.x_range", 32'(launch_x >= 10'd64 && launch_x <= 10'd575), 32'd1);
        chk("rnd.vx_set", 32'(launch_vx == 10'h3FE || launch_vx == 10'h3FF ||
                              launch_vx == 10'd1 || launch_vx == 10'd2), 32'd1);
        chk("rnd.vy_range", 32'($signed(launch_vy) >= -10'sd11 && $signed(launch_vy) <= -10'sd8), 32'd1);
      end else begin
        m_drop = m_drop + 8'd1;
      end
      chk("rnd.busy", 32'(slot_busy), 32'(m_busy));
      chk("rnd.drop", 32'(drop_count), 32'(m_drop));
      d = NS'($urandom_range(0, 15)) & NS'($urandom_range(0, 15));
      slot_done = d;
      step();
      slot_done = '0;
      model_done(d);
      m_busy = m_busy & ~d;
      chk("rnd.pulse_end", 32'(launch), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fruit_scheduler.md
# fruit_scheduler

Launch scheduler for the falling-fruit objects. Owns a fixed pool of fruit slots and, on a pseudo-random frame interval, picks the lowest free slot. It then issues that slot a one-cycle launch pulse with randomized start position, velocity and type. Slots are released when the fruit instance reports it has been sliced or has left the screen. Sits between the game-control FSM and the array of fruit motion blocks.

## Interface
- NUM_SLOTS, 4: number of fruit slots (1–8).
- SPAWN_MIN, 30: minimum frames between launch attempts (1–255).
- SPAWN_RANGE_LOG2, 5: random extra frames, 0..2^N−1 added to SPAWN_MIN (0–7; 0 = fixed interval).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame.
- game_en  in  1  scheduling enabled while high.
- slot_done  in  NUM_SLOTS  per-slot release pulse (sliced or off-screen).
- launch  out  NUM_SLOTS  one-hot, one-cycle launch pulse.
- launch_x  out  10  start X, unsigned pixels.
- launch_vx  out  10  X motion, two's complement.
- launch_vy  out  10  Y motion, two's complement (negative = upward).
- launch_type  out  2  fruit sprite select.
- slot_busy  out  NUM_SLOTS  slot occupied.
- drop_count  out  8  attempts with no free slot, saturating.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every Clk while game_en=1 and holds otherwise.
- FSM states and transitions:
  - IDLE → WAIT on game_en=1. Entering WAIT loads timer=SPAWN_MIN.
  - WAIT: each frame_tick decrements the timer. The tick that takes the timer to 0 moves the FSM to PICK.
  - PICK: priority-encode the lowest index with slot_busy=0.
    - Free slot found → LAUNCH.
    - No free slot → drop_count+1 (saturates at 255), reload timer, → WAIT.
  - LAUNCH: register outputs from the current LFSR value, assert launch[i], set slot_busy[i], reload timer, → WAIT.
- Launch fields from LFSR value L:
  - launch_x = 64 + L[8:0], giving range 64..575.
  - launch_vx from L[10:9]: 00→−2, 01→−1, 10→+1, 11→+2.
  - launch_vy = −(8 + L[12:11]), range −8..−11.
  - launch_type = L[14:13].
- Timer reload = SPAWN_MIN + L[SPAWN_RANGE_LOG2−1:0], computed 9 bits wide.
- slot_done:
  - Clears slot_busy the next edge.
  - Ignored on a non-busy slot.
  - A done and a launch to different slots in the same cycle both take effect.
  - A same-slot conflict cannot occur, because launches target only free slots.
- game_en=0 in any state → IDLE on the next edge. Any launch in progress is aborted. slot_busy and drop_count are retained, and done pulses are still honoured.
- frame_tick in IDLE, PICK or LAUNCH is ignored (not queued).

## Timing
- Reset: launch=0, all launch_* fields=0, slot_busy=0, drop_count=0, LFSR=LFSR_SEED, FSM=IDLE, timer=0.
- If the final frame_tick is sampled at edge T: PICK at T+1, and launch plus fields plus slot_busy bit are visible after edge T+2.
- launch is high for exactly one cycle.
- launch_* fields hold until the next launch.
- slot_done sampled at edge T clears slot_busy after edge T. The slot is eligible for a PICK evaluated at T+1.
- Reset_n asserted mid-launch clears everything immediately, with no partial pulse.

## Configuration
- FRUIT_SCHED_BOMB_EN defined:
  - Type 3 is a bomb.
  - Adds output launch_bomb (1 bit), asserted with launch when type=3.
  - Adds an internal bomb-in-flight flag, set on a bomb launch and cleared by slot_done of that slot.
  - While a bomb is in flight, a type-3 draw is forced to type 0, so at most one bomb is in flight.
- FRUIT_SCHED_BOMB_EN undefined: no launch_bomb port; all four types are ordinary fruit with no restriction.

## Test plan
- Reset, then game_en=1 with SPAWN_MIN=2, SPAWN_RANGE_LOG2=0, and frame_tick every 10 Clk → launch=4'b0001 two cycles after the 2nd tick, then 4'b0010, 4'b0100, 4'b1000 on each following 2nd tick.
- All 4 slots busy, two more interval expiries → no launch, drop_count=2. Then slot_done=4'b0100 → the next launch is 4'b0100.
- For every launch over 1000 frames: launch_x in 64..575, launch_vx ∈ {−2,−1,1,2}, launch_vy in −11..−8, launch one-hot for one cycle.
- slot_done[0] in the same cycle as a launch of slot 1 → slot_busy goes 0001→0010 with no lost update. slot_done on an idle slot → no change.
- game_en dropped in PICK → no launch, FSM IDLE, slot_busy retained. Reset_n pulsed mid-WAIT → all outputs 0 and LFSR=16'hACE1.
- With FRUIT_SCHED_BOMB_EN: force a type-3 draw while a bomb is busy → launch_type=0 and launch_bomb=0. After the bomb slot's slot_done, the next type-3 draw → launch_bomb=1.
